dvi_timing_sequencer: RTL and testbench

Generates the video timing and pixel-fetch sequence that drives the TFT/DVI output stage on `TFT_Clk`. Holds the display blanked until the CH7301C configuration reports done and software enables video. Then free-runs raster counters and issues pixel requests to the pixel source. Emits HSYNC/VSYNC/DE/RGB aligned to the pixel source's fixed read latency. Sits between the frame/pixel source and the DVI output stage, whose inputs it drives directly.

---
 rtl/dvi_timing_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_dvi_timing_sequencer.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dvi_timing_sequencer.sv
// dvi_timing_sequencer
//
// Video timing and pixel-fetch sequencer for the TFT/DVI output stage.
// Keeps the display blanked until the encoder reports configuration done
// and video is enabled. It then free-runs the raster counters, requests
// pixels from the pixel source, and emits sync/DE/RGB. These outputs are
// delayed to match the fixed read latency of the pixel source.
//
// Ports:
//   TFT_Clk                 pixel clock (sole clock)
//   TFT_Rst_n               asynchronous active-low reset
//   I2C_done                encoder configuration complete
//   enable                  video enable (level)
//   pix_req, pix_x, pix_y   pixel request and its column/line
//   pix_r, pix_g, pix_b     pixel data, valid PIX_LAT cycles after pix_req
//   frame_start             pulse with the request for pixel (0,0)
//   line_start              pulse with the request for column 0 of an active line
//   HSYNC, VSYNC, DE        timing to the DVI output stage
//   RED, GREEN, BLUE        pixel data to the DVI output stage
//   busy                    high while running or draining the last frame
module dvi_timing_sequencer #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   PIX_LAT  = 2
) (
    input  logic        TFT_Clk,
    input  logic        TFT_Rst_n,
    input  logic        I2C_done,
    input  logic        enable,
    output logic        pix_req,
    output logic [10:0] pix_x,
    output logic [10:0] pix_y,
    input  logic [7:0]  pix_r,
    input  logic [7:0]  pix_g,
    input  logic [7:0]  pix_b,
    output logic        frame_start,
    output logic        line_start,
    output logic        HSYNC,
    output logic        VSYNC,
    output logic        DE,
    output logic [7:0]  RED,
    output logic [7:0]  GREEN,
    output logic [7:0]  BLUE,
    output logic        busy
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
    localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [1:0] ST_WAIT_CFG = 2'd0;
    localparam logic [1:0] ST_RUN      = 2'd1;
    localparam logic [1:0] ST_DRAIN    = 2'd2;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [10:0] h;
    logic [10:0] v;
    logic        running;
    logic        frame_end;
    logic        active_c;
    logic        hs_c;
    logic        vs_c;

    assign running   = (state != ST_WAIT_CFG);
    assign frame_end = (h == H_LAST) && (v == V_LAST);

    // DRAIN only leaves for WAIT_CFG at the frame boundary, so a frame is
    // never cut short. Re-enabling during DRAIN wins over the boundary and
    // keeps the raster running without a break.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_WAIT_CFG: if (I2C_done && enable) state_nxt = ST_RUN;
            ST_RUN:      if (!enable)            state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                if (enable)         state_nxt = ST_RUN;
                else if (frame_end) state_nxt = ST_WAIT_CFG;
            end
            default:                state_nxt = ST_WAIT_CFG;
        endcase
    end

    always_ff @(posedge TFT_Clk or negedge TFT_Rst_n) begin
        if (!TFT_Rst_n) begin
            state <= ST_WAIT_CFG;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != ST_WAIT_CFG);
        end
    end

    // Raster counters: held at the origin while waiting, so the first
    // running cycle always requests pixel (0,0).
    always_ff @(posedge TFT_Clk or negedge TFT_Rst_n) begin
        if (!TFT_Rst_n) begin
            h <= '0;
            v <= '0;
        end else if (!running) begin
            h <= '0;
            v <= '0;
        end else if (h == H_LAST) begin
            h <= '0;
            v <= (v == V_LAST) ? 11'd0 : v + 11'd1;
        end else begin
            h <= h + 11'd1;
        end
    end

    assign active_c = (h < H_ACT) && (v < V_ACT);
    assign hs_c     = (h >= HS_BEG) && (h < HS_END);
    assign vs_c     = (v >= VS_BEG) && (v < VS_END);

    // Counter-domain request outputs, decoded straight from registered
    // state and counters.
    assign pix_req     = running && active_c;
    assign pix_x       = pix_req ? h : 11'd0;
    assign pix_y       = pix_req ? v : 11'd0;
    assign frame_start = running && (h == 11'd0) && (v == 11'd0);
    assign line_start  = running && (h == 11'd0) && (v < V_ACT);

    logic de_in;
    logic hs_in;
    logic vs_in;

    assign de_in = pix_req;
    assign hs_in = (running && hs_c) ? HS_POL : ~HS_POL;
    assign vs_in = (running && vs_c) ? VS_POL : ~VS_POL;

    // Stage 0 .. PIX_LAT: timing delay line, one register per cycle of
    // pixel-source latency plus the RGB capture register.
    logic [PIX_LAT:0] de_p;
    logic [PIX_LAT:0] hs_p;
    logic [PIX_LAT:0] vs_p;

    always_ff @(posedge TFT_Clk or negedge TFT_Rst_n) begin
        if (!TFT_Rst_n) begin
            de_p <= '0;
            hs_p <= {(PIX_LAT + 1){~HS_POL}};
            vs_p <= {(PIX_LAT + 1){~VS_POL}};
        end else begin
            de_p[0] <= de_in;
            hs_p[0] <= hs_in;
            vs_p[0] <= vs_in;
            for (int i = 1; i <= PIX_LAT; i++) begin
                de_p[i] <= de_p[i-1];
                hs_p[i] <= hs_p[i-1];
                vs_p[i] <= vs_p[i-1];
            end
        end
    end

    // DE belonging to the pixel whose data is on pix_* this cycle. With zero
    // latency that is the request itself.
    logic de_lat;

    generate
        if (PIX_LAT == 0) begin : g_lat0
            assign de_lat = de_in;
        end else begin : g_latn
            assign de_lat = de_p[PIX_LAT-1];
        end
    endgenerate

    // Stage PIX_LAT: RGB capture, forced to zero outside the active area.
    always_ff @(posedge TFT_Clk or negedge TFT_Rst_n) begin
        if (!TFT_Rst_n) begin
            RED   <= '0;
            GREEN <= '0;
            BLUE  <= '0;
        end else if (de_lat) begin
            RED   <= pix_r;
            GREEN <= pix_g;
            BLUE  <= pix_b;
        end else begin
            RED   <= '0;
            GREEN <= '0;
            BLUE  <= '0;
        end
    end

    assign DE    = de_p[PIX_LAT];
    assign HSYNC = hs_p[PIX_LAT];
    assign VSYNC = vs_p[PIX_LAT];

endmodule

// File: tb/tb_dvi_timing_sequencer.sv
// Bench for dvi_timing_sequencer: one instance with default timing and
// PIX_LAT=2, plus two instances with tiny timing at PIX_LAT=0 and 7.
// Expected behaviour comes from hand-written vectors and from a model that
// derives every output from the time elapsed since the first running cycle.
module tb_dvi_timing_sequencer;

    typedef struct packed {
        logic        req;
        logic [10:0] x;
        logic [10:0] y;
        logic        fs;
        logic        ls;
        logic        de;
        logic        hs;
        logic        vs;
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
        logic        busy;
    } obs_t;

    typedef struct {
        int   t;
        obs_t e;
    } vec_t;

    localparam int BIG = 1 << 30;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic rst_n;
    logic done_d, en_d, done_s, en_s;

    logic        req_d, fs_d, ls_d, hs_d, vs_d, de_d, busy_d;
    logic [10:0] x_d, y_d;
    logic [7:0]  r_d, g_d, b_d, pat_d, src_d;
    logic        req_a, fs_a, ls_a, hs_a, vs_a, de_a, busy_a;
    logic [10:0] x_a, y_a;
    logic [7:0]  r_a, g_a, b_a, pat_a;
    logic        req_b, fs_b, ls_b, hs_b, vs_b, de_b, busy_b;
    logic [10:0] x_b, y_b;
    logic [7:0]  r_b, g_b, b_b, pat_b, src_b;

    // Pixel sources: pattern (x^y)&0xFF for requested pixels, junk otherwise,
    // delivered after the instance's read latency.
    assign pat_d = req_d ? 8'(x_d ^ y_d) : 8'hA5;
    assign pat_a = req_a ? 8'(x_a ^ y_a) : 8'hA5;
    assign pat_b = req_b ? 8'(x_b ^ y_b) : 8'hA5;

    logic [7:0] dl_d [2];
    logic [7:0] dl_b [7];
    always @(posedge clk) begin
        dl_d[0] <= pat_d;
        dl_d[1] <= dl_d[0];
        dl_b[0] <= pat_b;
        for (int i = 1; i < 7; i++) dl_b[i] <= dl_b[i-1];
    end
    assign src_d = dl_d[1];
    assign src_b = dl_b[6];

    dvi_timing_sequencer dut_d (
        .TFT_Clk(clk), .TFT_Rst_n(rst_n), .I2C_done(done_d), .enable(en_d),
        .pix_req(req_d), .pix_x(x_d), .pix_y(y_d),
        .pix_r(src_d), .pix_g(src_d), .pix_b(src_d),
        .frame_start(fs_d), .line_start(ls_d),
        .HSYNC(hs_d), .VSYNC(vs_d), .DE(de_d),
        .RED(r_d), .GREEN(g_d), .BLUE(b_d), .busy(busy_d)
    );

    dvi_timing_sequencer #(
        .H_ACTIVE(4), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .PIX_LAT(0)
    ) dut_a (
        .TFT_Clk(clk), .TFT_Rst_n(rst_n), .I2C_done(done_s), .enable(en_s),
        .pix_req(req_a), .pix_x(x_a), .pix_y(y_a),
        .pix_r(pat_a), .pix_g(pat_a), .pix_b(pat_a),
        .frame_start(fs_a), .line_start(ls_a),
        .HSYNC(hs_a), .VSYNC(vs_a), .DE(de_a),
        .RED(r_a), .GREEN(g_a), .BLUE(b_a), .busy(busy_a)
    );

    dvi_timing_sequencer #(
        .H_ACTIVE(4), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .PIX_LAT(7)
    ) dut_b (
        .TFT_Clk(clk), .TFT_Rst_n(rst_n), .I2C_done(done_s), .enable(en_s),
        .pix_req(req_b), .pix_x(x_b), .pix_y(y_b),
        .pix_r(src_b), .pix_g(src_b), .pix_b(src_b),
        .frame_start(fs_b), .line_start(ls_b),
        .HSYNC(hs_b), .VSYNC(vs_b), .DE(de_b),
        .RED(r_b), .GREEN(g_b), .BLUE(b_b), .busy(busy_b)
    );

    obs_t obs_d, obs_a, obs_b;
    assign obs_d = {req_d, x_d, y_d, fs_d, ls_d, de_d, hs_d, vs_d, r_d, g_d, b_d, busy_d};
    assign obs_a = {req_a, x_a, y_a, fs_a, ls_a, de_a, hs_a, vs_a, r_a, g_a, b_a, busy_a};
    assign obs_b = {req_b, x_b, y_b, fs_b, ls_b, de_b, hs_b, vs_b, r_b, g_b, b_b, busy_b};

    int total = 0;
    int bad   = 0;

    task automatic chk_int(input string name, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, exp);
        end
    endtask

    task automatic chk_obs(input string name, input obs_t got, input obs_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    function automatic obs_t mk(input logic req, input int x, input int y,
                                input logic fs, input logic ls, input logic de,
                                input logic hs, input logic vs, input int rgb,
                                input logic busy);
        obs_t o;
        o.req = req; o.x = 11'(x); o.y = 11'(y);
        o.fs = fs; o.ls = ls; o.de = de; o.hs = hs; o.vs = vs;
        o.r = 8'(rgb); o.g = 8'(rgb); o.b = 8'(rgb);
        o.busy = busy;
        return o;
    endfunction

    // Outputs at time t (cycles since the first running cycle), given the
    // running window length, output lag and timing (active-low syncs).
    function automatic obs_t model(input int t, input int run_len, input int lat,
                                   input int ha, input int hf, input int hsw, input int hb,
                                   input int va, input int vf, input int vsw, input int vb);
        obs_t o;
        int ht, vt, h, v, tc;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        o = '0;
        o.hs = 1'b1;
        o.vs = 1'b1;
        if (t >= 0 && t < run_len) begin
            h = t % ht;
            v = (t / ht) % vt;
            o.busy = 1'b1;
            if (h < ha && v < va) begin
                o.req = 1'b1;
                o.x = 11'(h);
                o.y = 11'(v);
            end
            o.fs = (h == 0) && (v == 0);
            o.ls = (h == 0) && (v < va);
        end
        tc = t - lat - 1;
        if (tc >= 0 && tc < run_len) begin
            h = tc % ht;
            v = (tc / ht) % vt;
            o.de = (h < ha) && (v < va);
            o.hs = !((h >= ha + hf) && (h < ha + hf + hsw));
            o.vs = !((v >= va + vf) && (v < va + vf + vsw));
            if (o.de) begin
                o.r = 8'(h ^ v); o.g = 8'(h ^ v); o.b = 8'(h ^ v);
            end
        end
        return o;
    endfunction

    int   start_d = BIG;
    int   start_s = BIG;
    int   run_s   = 240;
    logic mon_on  = 1'b0;
    logic gate_on = 1'b0;
    logic meas_en = 1'b0;
    int   err_d = 0, err_a = 0, err_b = 0, ngate = 0;
    int   nde_line = 0, nhs_line = 0, rise1 = -1, rise2 = -1, fall1 = -1;
    logic prev_de_d = 1'b0, prev_hs_d = 1'b1;
    int   nde_a = 0, nde_b = 0, nvs_a = 0, nvs_b = 0, nhs_a = 0, nhs_b = 0;
    int   nfs_a = 0, nfs_b = 0, fde_a = -1, fde_b = -1, fhs_a = -1, fhs_b = -1;

    always @(negedge clk) begin
        int   td, ts;
        obs_t e;
        if (mon_on) begin
            td = cyc - start_d;
            e = model(td, BIG, 2, 640, 16, 96, 48, 480, 10, 2, 33);
            if (obs_d !== e) begin
                err_d++;
                if (err_d <= 4) $display("  diff stream_d t=%0d got=%h want=%h", td, obs_d, e);
            end
            if (meas_en && td >= 0 && td < 803) begin
                if (de_d) nde_line++;
                if (!hs_d) nhs_line++;
            end
            if (meas_en && de_d && !prev_de_d) begin
                if (rise1 < 0) rise1 = td;
                else if (rise2 < 0) rise2 = td;
            end
            if (meas_en && !hs_d && prev_hs_d && fall1 < 0) fall1 = td;
            prev_de_d = de_d;
            prev_hs_d = hs_d;
            if (gate_on && req_d) ngate++;

            ts = cyc - start_s;
            e = model(ts, run_s, 0, 4, 2, 2, 2, 3, 1, 1, 1);
            if (obs_a !== e) begin
                err_a++;
                if (err_a <= 4) $display("  diff stream_a t=%0d got=%h want=%h", ts, obs_a, e);
            end
            e = model(ts, run_s, 7, 4, 2, 2, 2, 3, 1, 1, 1);
            if (obs_b !== e) begin
                err_b++;
                if (err_b <= 4) $display("  diff stream_b t=%0d got=%h want=%h", ts, obs_b, e);
            end
            if (ts >= 0) begin
                if (de_a) nde_a++;
                if (de_b) nde_b++;
                if (!vs_a) nvs_a++;
                if (!vs_b) nvs_b++;
                if (!hs_a) nhs_a++;
                if (!hs_b) nhs_b++;
                if (fs_a) nfs_a++;
                if (fs_b) nfs_b++;
                if (de_a && fde_a < 0) fde_a = ts;
                if (de_b && fde_b < 0) fde_b = ts;
                if (!hs_a && fhs_a < 0) fhs_a = ts;
                if (!hs_b && fhs_b < 0) fhs_b = ts;
            end
        end
    end

    task automatic wait_d(input int n);
        do @(negedge clk); while (cyc - start_d < n);
    endtask

    task automatic wait_s(input int n);
        do @(negedge clk); while (cyc - start_s < n);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog expired");
    end

    vec_t tbl [18];

    initial begin
        // t, req, x, y, fs, ls, de, hs, vs, rgb, busy for the default instance
        tbl[0]  = '{0,    mk(1,   0, 0, 1, 1, 0, 1, 1,   0, 1)};
        tbl[1]  = '{1,    mk(1,   1, 0, 0, 0, 0, 1, 1,   0, 1)};
        tbl[2]  = '{3,    mk(1,   3, 0, 0, 0, 1, 1, 1,   0, 1)};
        tbl[3]  = '{5,    mk(1,   5, 0, 0, 0, 1, 1, 1,   2, 1)};
        tbl[4]  = '{639,  mk(1, 639, 0, 0, 0, 1, 1, 1, 124, 1)};
        tbl[5]  = '{640,  mk(0,   0, 0, 0, 0, 1, 1, 1, 125, 1)};
        tbl[6]  = '{642,  mk(0,   0, 0, 0, 0, 1, 1, 1, 127, 1)};
        tbl[7]  = '{643,  mk(0,   0, 0, 0, 0, 0, 1, 1,   0, 1)};
        tbl[8]  = '{658,  mk(0,   0, 0, 0, 0, 0, 1, 1,   0, 1)};
        tbl[9]  = '{659,  mk(0,   0, 0, 0, 0, 0, 0, 1,   0, 1)};
        tbl[10] = '{754,  mk(0,   0, 0, 0, 0, 0, 0, 1,   0, 1)};
        tbl[11] = '{755,  mk(0,   0, 0, 0, 0, 0, 1, 1,   0, 1)};
        tbl[12] = '{800,  mk(1,   0, 1, 0, 1, 0, 1, 1,   0, 1)};
        tbl[13] = '{803,  mk(1,   3, 1, 0, 0, 1, 1, 1,   1, 1)};
        tbl[14] = '{806,  mk(1,   6, 1, 0, 0, 1, 1, 1,   2, 1)};
        tbl[15] = '{2450, mk(1,  50, 3, 0, 0, 1, 1, 1,  44, 1)};
        tbl[16] = '{3203, mk(1,   3, 4, 0, 0, 1, 1, 1,   4, 1)};
        tbl[17] = '{3400, mk(1, 200, 4, 0, 0, 1, 1, 1, 193, 1)};

        rst_n = 1'b1;
        done_d = 1'b0; en_d = 1'b0; done_s = 1'b0; en_s = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mon_on = 1'b1;
        chk_obs("reset_state_d", obs_d, mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0));

        // Small-timing session: 60-cycle frames, enable toggled across DRAIN,
        // and enable dropped on a frame's last cycle, giving four frames.
        en_s = 1'b1; done_s = 1'b1;
        @(posedge clk);
        #1 start_s = cyc;
        wait_s(0);
        chk_int("small_first_req_fs", int'({req_a, fs_a, ls_a, x_a, y_a}), int'({3'b111, 22'd0}));
        wait_s(30);  done_s = 1'b0;
        wait_s(70);  en_s = 1'b0;
        wait_s(90);  en_s = 1'b1;
        wait_s(122);
        chk_int("resume_raster", int'({req_a, x_a, y_a}), int'({1'b1, 11'd2, 11'd0}));
        wait_s(179); en_s = 1'b0;
        wait_s(239);
        chk_int("busy_last_drain", int'(busy_a), 1);
        wait_s(240);
        chk_int("busy_after_frame", int'(busy_a), 0);
        chk_int("idle_no_req", int'(req_a), 0);
        wait_s(260);
        chk_int("stream_a_errors", err_a, 0);
        chk_int("stream_b_errors", err_b, 0);
        chk_int("de_count_a", nde_a, 48);
        chk_int("de_count_b", nde_b, 48);
        chk_int("frame_start_count_a", nfs_a, 4);
        chk_int("frame_start_count_b", nfs_b, 4);
        chk_int("vsync_low_a", nvs_a, 40);
        chk_int("vsync_low_b", nvs_b, 40);
        chk_int("hsync_low_a", nhs_a, 48);
        chk_int("hsync_low_b", nhs_b, 48);
        chk_int("first_de_a", fde_a, 1);
        chk_int("first_de_b", fde_b, 8);
        chk_int("first_hs_a", fhs_a, 7);
        chk_int("first_hs_b", fhs_b, 14);

        // Default instance: enable without configuration done stays blank.
        en_d = 1'b1;
        gate_on = 1'b1;
        repeat (1000) @(negedge clk);
        gate_on = 1'b0;
        chk_int("gate_no_req", ngate, 0);
        chk_int("gate_busy", int'(busy_d), 0);

        meas_en = 1'b1;
        done_d = 1'b1;
        @(posedge clk);
        #1 start_d = cyc;
        for (int i = 0; i < 18; i++) begin
            wait_d(tbl[i].t);
            chk_obs($sformatf("vec%0d_t%0d", i, tbl[i].t), obs_d, tbl[i].e);
        end
        meas_en = 1'b0;
        chk_int("line_first_de", rise1, 3);
        chk_int("line_de_len", nde_line, 640);
        chk_int("line_hs_len", nhs_line, 96);
        chk_int("line_de_to_hs", fall1 - rise1, 656);
        chk_int("line_period", rise2 - rise1, 800);

        // Mid-line asynchronous reset, away from any clock edge.
        #3;
        start_d = BIG;
        rst_n = 1'b0;
        #1;
        chk_obs("async_reset", obs_d, mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        done_d = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ngate = 0;
        gate_on = 1'b1;
        repeat (50) @(negedge clk);
        gate_on = 1'b0;
        chk_int("post_reset_no_req", ngate, 0);

        done_d = 1'b1;
        @(posedge clk);
        #1 start_d = cyc;
        wait_d(0);
        chk_int("restart_fs_req", int'({fs_d, req_d, busy_d}), 7);
        wait_d(3);
        chk_int("restart_de", int'(de_d), 1);
        wait_d(20);
        chk_int("stream_d_errors", err_d, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
